// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Shares one single-port, synchronous-read memory between the instruction
// fetch port (if_*, read-only) and the data port (d_*, loads and stores).
// Only one memory transaction is in flight at a time. Each transaction goes
// through three steps: arbitrate, issue (one cycle), then wait MEM_LAT
// cycles (reads only) before the data is returned to the winning port.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin between the two ports.
//                  undefined -> the data port has priority. After STARVE_MAX
//                               lost arbitrations in a row, fetch wins once.
//
// Ports:
//   clk1, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                  fetch request
//   if_gnt/if_rvalid/if_rdata       fetch grant pulse, data-valid pulse, data
//   d_req/d_we/d_addr/d_wdata       data request (d_we=1 is a store)
//   d_gnt/d_rvalid/d_rdata          data grant pulse, load-valid pulse, data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory macro interface
//   busy                            a read is outstanding
// All outputs are registered.
module mips_mem_arbiter #(
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = 3;
  localparam int unsigned SW = 4;
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;        // 1 = data port owns the access
  logic          if_gnt_q, if_gnt_d;
  logic          d_gnt_q, d_gnt_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;
  logic          accept_c;                // requests may be sampled this edge
  logic          pick_d_c;                // 1 = data wins this arbitration
  logic          if_prio_c;               // fetch wins a tie

`ifdef MEM_ARB_RR_EN
  logic          last_q, last_d;          // 1 = data port was granted last
  assign if_prio_c = last_q;
`else
  logic [SW-1:0] starve_q, starve_d;
  assign if_prio_c = (starve_q == SW'(STARVE_MAX));
`endif

  // State and output registers
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b1;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q      <= 1'b1;
`else
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  // Next-state, arbitration and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = 1'b0;
    accept_c    = 1'b0;
    pick_d_c    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`else
    starve_d    = starve_q;
`endif

    case (state_q)
      ST_IDLE: accept_c = 1'b1;
      ST_ISSUE: begin
        // A store completes in its issue cycle, so the next request can go
        // out straight away. A read has to wait for the memory.
        if (mem_we_q) begin
          accept_c = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = LAT_LOAD;
          busy_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - CW'(1);
          busy_d = 1'b1;
        end else begin
          // Last wait cycle: mem_rdata is valid now. Register it for the
          // port that owns the read.
          accept_c = 1'b1;
          if (owner_q) begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end
        end
      end
      default: accept_c = 1'b1;
    endcase

    if (accept_c) begin
      state_d = ST_IDLE;
      if (if_req || d_req) begin
        pick_d_c = d_req && !(if_req && if_prio_c);
        state_d  = ST_ISSUE;
        mem_en_d = 1'b1;
        owner_d  = pick_d_c;
        if (pick_d_c) begin
          d_gnt_d     = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          busy_d      = !d_we;
        end else begin
          if_gnt_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          busy_d      = 1'b1;
        end
`ifdef MEM_ARB_RR_EN
        last_d = pick_d_c;
`endif
      end
    end

`ifndef MEM_ARB_RR_EN
    // The starve count is the number of arbitrations in a row that fetch has
    // lost. Fetch dropping its request also clears the count.
    if (!if_req) begin
      starve_d = '0;
    end else if (accept_c) begin
      if (!pick_d_c) begin
        starve_d = '0;
      end else if (starve_q != SW'(STARVE_MAX)) begin
        starve_d = starve_q + SW'(1);
      end
    end
`endif
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed testbench for mips_mem_arbiter (MEM_LAT=1, STARVE_MAX=4).
// The bench drives inputs and samples outputs on the falling clock edge.
// It also contains a synchronous-read memory model with one cycle of latency.
module tb_mips_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk1 = 1'b0;
  logic          rst  = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [0:1023];

  mips_mem_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(4)
  ) dut (
    .clk1(clk1), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  // Memory model: preloaded contents, then one synchronous read/write port
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[3]   = 32'h0000_0abc;
    mem[5]   = 32'h280a_00c8;
    mem[6]   = 32'h1234_5678;
    mem[200] = 32'd7;
    forever begin
      @(posedge clk1);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata     <= mem[mem_addr];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 time units");
    $fatal(1);
  end

  task automatic test_reset();
    int seen;
    repeat (2) @(negedge clk1);
    n_cmp++;
    if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000000",
                        {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      n_err++; $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h d_rdata=%h want 0",
                        mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    rst = 1'b0;
    @(negedge clk1);
    if_req = 1'b1; if_addr = 10'd3;
    @(negedge clk1);                       // C1
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_gnt: if_gnt=%b want 1", if_gnt);
    end
    if_req = 1'b0;
    @(negedge clk1);                       // WAIT
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_busy: busy=%b want 1", busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy, mem_addr} !== '0) begin
      n_err++; $display("FAIL reset_mid: ctrl=%b addr=%h want all 0",
                        {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}, mem_addr);
    end
    @(negedge clk1);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk1);
      if (if_rvalid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++; $display("FAIL reset_no_rvalid: pulses=%0d want 0", seen);
    end
    if_req = 1'b1; if_addr = 10'd3;
    @(negedge clk1);
    n_cmp++;
    if ({if_gnt, mem_en, mem_addr} !== {1'b1, 1'b1, 10'd3}) begin
      n_err++; $display("FAIL reset_after_gnt: gnt=%b en=%b addr=%0d want 1 1 3",
                        if_gnt, mem_en, mem_addr);
    end
    if_req = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    n_cmp++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h0000_0abc}) begin
      n_err++; $display("FAIL reset_after_data: rvalid=%b rdata=%h want 1 00000abc",
                        if_rvalid, if_rdata);
    end
    @(negedge clk1);
  endtask

  task automatic test_if_read();
    int pulses;
    pulses = 0;
    if_req = 1'b1; if_addr = 10'd5;
    @(negedge clk1);                       // C1
    n_cmp++;
    if ({if_gnt, d_gnt, mem_en, mem_we, mem_addr, busy} !== {4'b1010, 10'd5, 1'b1}) begin
      n_err++; $display("FAIL ifrd_c1: if_gnt=%b d_gnt=%b en=%b we=%b addr=%0d busy=%b want 1 0 1 0 5 1",
                        if_gnt, d_gnt, mem_en, mem_we, mem_addr, busy);
    end
    if_req = 1'b0;
    @(negedge clk1);                       // C1+1
    if (if_rvalid === 1'b1) pulses++;
    n_cmp++;
    if ({if_gnt, mem_en, busy} !== 3'b001) begin
      n_err++; $display("FAIL ifrd_c2: gnt=%b en=%b busy=%b want 0 0 1", if_gnt, mem_en, busy);
    end
    @(negedge clk1);                       // C1+2
    if (if_rvalid === 1'b1) pulses++;
    n_cmp++;
    if ({if_rvalid, if_rdata, busy} !== {1'b1, 32'h280a_00c8, 1'b0}) begin
      n_err++; $display("FAIL ifrd_data: rvalid=%b rdata=%h busy=%b want 1 280a00c8 0",
                        if_rvalid, if_rdata, busy);
    end
    repeat (3) begin
      @(negedge clk1);
      if (if_rvalid === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_err++; $display("FAIL ifrd_pulses: got %0d want 1", pulses);
    end
    n_cmp++;
    if (if_rdata !== 32'h280a_00c8) begin
      n_err++; $display("FAIL ifrd_hold: rdata=%h want 280a00c8", if_rdata);
    end
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 10'd6;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd200;
    @(negedge clk1);                       // C1
    n_cmp++;
    if ({d_gnt, if_gnt, mem_addr} !== {2'b10, 10'd200}) begin
      n_err++; $display("FAIL cont_first: d_gnt=%b if_gnt=%b addr=%0d want 1 0 200",
                        d_gnt, if_gnt, mem_addr);
    end
    d_req = 1'b0;
    @(negedge clk1);                       // WAIT
    n_cmp++;
    if ({d_gnt, if_gnt} !== 2'b00) begin
      n_err++; $display("FAIL cont_wait: d_gnt=%b if_gnt=%b want 0 0", d_gnt, if_gnt);
    end
    @(negedge clk1);                       // data return and fetch issue overlap
    n_cmp++;
    if ({d_rvalid, d_rdata, if_gnt, mem_addr} !== {1'b1, 32'd7, 1'b1, 10'd6}) begin
      n_err++; $display("FAIL cont_second: d_rvalid=%b d_rdata=%0d if_gnt=%b addr=%0d want 1 7 1 6",
                        d_rvalid, d_rdata, if_gnt, mem_addr);
    end
    if_req = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    n_cmp++;
    if ({if_rvalid, if_rdata, d_rvalid} !== {1'b1, 32'h1234_5678, 1'b0}) begin
      n_err++; $display("FAIL cont_ifdata: if_rvalid=%b if_rdata=%h d_rvalid=%b want 1 12345678 0",
                        if_rvalid, if_rdata, d_rvalid);
    end
    @(negedge clk1);
  endtask

  task automatic test_back_to_back();
    int rv;
    rv = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd198; d_wdata = 32'd5040;
    @(negedge clk1);                       // C1
    if (d_rvalid === 1'b1) rv++;
    n_cmp++;
    if ({d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd198, 32'd5040}) begin
      n_err++; $display("FAIL st_first: gnt=%b en=%b we=%b addr=%0d wdata=%0d want 1 1 1 198 5040",
                        d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    d_addr = 10'd199; d_wdata = 32'd1;
    @(negedge clk1);                       // C2
    if (d_rvalid === 1'b1) rv++;
    n_cmp++;
    if ({d_gnt, mem_en, mem_we, mem_addr, mem_wdata, busy} !== {3'b111, 10'd199, 32'd1, 1'b0}) begin
      n_err++; $display("FAIL st_second: gnt=%b en=%b we=%b addr=%0d wdata=%0d busy=%b want 1 1 1 199 1 0",
                        d_gnt, mem_en, mem_we, mem_addr, mem_wdata, busy);
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk1);
    if (d_rvalid === 1'b1) rv++;
    n_cmp++;
    if ({mem_en, mem_we, d_gnt} !== 3'b000) begin
      n_err++; $display("FAIL st_idle: en=%b we=%b gnt=%b want 0 0 0", mem_en, mem_we, d_gnt);
    end
    repeat (2) begin
      @(negedge clk1);
      if (d_rvalid === 1'b1) rv++;
    end
    n_cmp++;
    if (rv !== 0) begin
      n_err++; $display("FAIL st_no_rvalid: pulses=%0d want 0", rv);
    end
    n_cmp++;
    if ({mem[198], mem[199]} !== {32'd5040, 32'd1}) begin
      n_err++; $display("FAIL st_mem: mem198=%0d mem199=%0d want 5040 1", mem[198], mem[199]);
    end
  endtask

  task automatic test_starvation();
    logic g [0:15];
    int   k;
    int   both;
    logic exp_g;
    k = 0; both = 0;
    for (int i = 0; i < 16; i++) g[i] = 1'b0;
    if_req = 1'b1; if_addr = 10'd6;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd200;
    repeat (30) begin
      @(negedge clk1);
      if (if_gnt === 1'b1 && d_gnt === 1'b1) both++;
      if ((if_gnt === 1'b1 || d_gnt === 1'b1) && k < 16) begin
        g[k] = d_gnt;
        k++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk1);
    n_cmp++;
    if (both !== 0) begin
      n_err++; $display("FAIL starve_both: double grants=%0d want 0", both);
    end
    n_cmp++;
    if (k < 10) begin
      n_err++; $display("FAIL starve_count: grants=%0d want >= 10", k);
    end
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
      if (i > 0) begin
        exp_g = ~g[i-1];
        n_cmp++;
        if (g[i] !== exp_g) begin
          n_err++; $display("FAIL starve_rr_%0d: d_gnt=%b want %b", i, g[i], exp_g);
        end
      end
`else
      exp_g = ((i % 5) != 4);
      n_cmp++;
      if (g[i] !== exp_g) begin
        n_err++; $display("FAIL starve_seq_%0d: d_gnt=%b want %b", i, g[i], exp_g);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_contention();
    test_back_to_back();
    test_starvation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
